// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the CPU/DMA memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arbState_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam int DEF_CPU_BURST_MAX  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Smallest counter width able to hold maxVal (never below 1 bit).
  function automatic int ctrWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the arbiter: CPU first, DMA once the CPU burst limit is hit.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int CPU_BURST_MAX = DEF_CPU_BURST_MAX
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   cpu_req,
  input  logic   dma_req,
  input  logic   idle,
  input  logic   grantEn,
  output logic   grantValid,
  output owner_t winner
);

  localparam int CW = ctrWidth(CPU_BURST_MAX);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(CPU_BURST_MAX);

  logic [CW-1:0] burstCnt;
  logic          burstFull;

  always_comb begin
    burstFull  = (burstCnt == BURST_LIMIT);
    grantValid = grantEn && (cpu_req || dma_req);
    winner     = (dma_req && (!cpu_req || burstFull)) ? OWN_DMA : OWN_CPU;
  end

  // Counts CPU grants that starved a waiting DMA; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burstCnt <= '0;
    end else if (grantValid && winner == OWN_DMA) begin
      burstCnt <= '0;
    end else if (grantValid && dma_req && !burstFull) begin
      burstCnt <= burstCnt + 1'b1;
    end else if (idle && !dma_req) begin
      burstCnt <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU, DMA) single memory port arbiter with access timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CPU_BURST_MAX  = DEF_CPU_BURST_MAX,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  localparam int TW = ctrWidth(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  arbState_t     state;
  owner_t        owner;
  owner_t        winner;
  logic          grantValid;
  logic          grantEn;
  logic [TW-1:0] toutCnt;
  logic [31:0]   respData;
  logic          respErr;

  // The cycle carrying an ack is the IDLE turnaround: the requester has not yet
  // dropped its request, so granting here would replay the finished access.
  assign grantEn = (state == IDLE) && !cpu_ack && !dma_ack;

  mem_arb_prio #(
    .CPU_BURST_MAX(CPU_BURST_MAX)
  ) uPrio (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .dma_req   (dma_req),
    .idle      (state == IDLE),
    .grantEn   (grantEn),
    .grantValid(grantValid),
    .winner    (winner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      toutCnt   <= '0;
      respData  <= '0;
      respErr   <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
      dma_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
      dma_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grantValid) begin
            owner     <= winner;
            mem_en    <= 1'b1;
            mem_we    <= (winner == OWN_DMA) ? dma_we    : cpu_we;
            mem_addr  <= (winner == OWN_DMA) ? dma_addr  : cpu_addr;
            mem_wdata <= (winner == OWN_DMA) ? dma_wdata : cpu_wdata;
            toutCnt   <= '0;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ack || toutCnt == TOUT_LAST) begin
            respData  <= (mem_ack && !mem_we) ? mem_rdata : 32'h0;
            respErr   <= !mem_ack;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= RESP;
          end else begin
            toutCnt <= toutCnt + 1'b1;
          end
        end
        RESP: begin
          if (owner == OWN_DMA) begin
            dma_ack   <= 1'b1;
            dma_rdata <= respData;
            dma_err   <= respErr;
          end else begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= respData;
            cpu_err   <= respErr;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: expected responses are queued at issue time and a monitor checks each ack.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_ack, cpu_err, dma_ack, dma_err;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_en, mem_we, mem_ack, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .CPU_BURST_MAX (4),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .cpu_err  (cpu_err),
    .dma_req  (dma_req),
    .dma_we   (dma_we),
    .dma_addr (dma_addr),
    .dma_wdata(dma_wdata),
    .dma_ack  (dma_ack),
    .dma_rdata(dma_rdata),
    .dma_err  (dma_err),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .busy     (busy)
  );

  typedef struct packed {
    logic        isDma;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ackDelay = 0;
  int   memCnt = 0;
  logic spurious = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic waitAck(input int maxCyc, output int tAck);
    tAck = -1;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
        tAck = cyc;
        break;
      end
    end
    if (tAck < 0) begin
      checks++;
      errors++;
      $display("FAIL ackTimeout: no ack within %0d cycles", maxCyc);
    end
  endtask

  // Memory model: ack in the ackDelay-th cycle of mem_en (-1 = never), data from memData.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_en) begin
        mem_ack   = (ackDelay >= 0) && (memCnt == ackDelay);
        mem_rdata = mem_ack ? memData(mem_addr) : 32'h0;
        memCnt++;
      end else begin
        memCnt    = 0;
        mem_ack   = spurious;
        mem_rdata = spurious ? 32'hBAD0BAD0 : 32'h0;
      end
    end
  end

  // Monitor: every ack pops one expected response; data/err must be 0 outside acks.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (cyc >= 1) begin
      if (cpu_ack || dma_ack) begin
        chk("dualAck", 32'(cpu_ack & dma_ack), 32'h0);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedAck: cpu_ack=%0b dma_ack=%0b at cycle %0d", cpu_ack, dma_ack, cyc);
        end else begin
          e = expQ.pop_front();
          chk("ackOwner", 32'(dma_ack), 32'(e.isDma));
          chk("ackRdata", e.isDma ? dma_rdata : cpu_rdata, e.rdata);
          chk("ackErr", 32'(e.isDma ? dma_err : cpu_err), 32'(e.err));
        end
      end
      if (!cpu_ack) chk("cpuIdleZero", cpu_rdata | 32'(cpu_err), 32'h0);
      if (!dma_ack) chk("dmaIdleZero", dma_rdata | 32'(dma_err), 32'h0);
    end
  end

  initial begin
    int t0, tAck, n, enCnt;
    logic gotAck;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("resetCtrl", 32'({cpu_ack, cpu_err, dma_ack, dma_err, mem_en, mem_we, busy}), 32'h0);
    chk("resetData", cpu_rdata | dma_rdata | mem_addr | mem_wdata, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // CPU read 0x100, mem_ack two cycles after mem_en rises
    ackDelay = 2;
    @(posedge clk); #1;
    expQ.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    cpu_we = 1'b0; cpu_addr = 32'h100; cpu_req = 1'b1; t0 = cyc;
    waitAck(20, tAck);
    chk("readLatency", 32'(tAck - t0), 32'd5);
    @(posedge clk); #1 cpu_req = 1'b0;

    // CPU write with immediate mem_ack: minimum latency, write returns 0
    ackDelay = 0;
    @(posedge clk); #1;
    expQ.push_back('{1'b0, 32'h0, 1'b0});
    cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h55; cpu_req = 1'b1; t0 = cyc;
    waitAck(20, tAck);
    chk("minLatency", 32'(tAck - t0), 32'd3);
    @(posedge clk); #1 cpu_req = 1'b0; cpu_we = 1'b0;

    // Both requesters held: C,C,C,C,D,C,C,C,C,D
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) expQ.push_back('{1'b1, 32'h5A5A0400, 1'b0});
      else                  expQ.push_back('{1'b0, 32'h5A5A0300, 1'b0});
    end
    cpu_addr = 32'h300; dma_we = 1'b0; dma_addr = 32'h400;
    cpu_req = 1'b1; dma_req = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) n++;
    end
    chk("burstAckCount", 32'(n), 32'd10);
    @(posedge clk); #1 cpu_req = 1'b0; dma_req = 1'b0;

    // DMA write, mem_ack withheld: 255 cycles of mem_en then timeout
    ackDelay = -1;
    @(posedge clk); #1;
    expQ.push_back('{1'b1, 32'h0, 1'b1});
    dma_we = 1'b1; dma_addr = 32'h2000; dma_wdata = 32'h12345678; dma_req = 1'b1;
    enCnt = 0; gotAck = 1'b0;
    for (int i = 0; i < 400 && !gotAck; i++) begin
      @(negedge clk);
      if (mem_en) begin
        enCnt++;
        if (enCnt == 1) begin
          chk("toMemWe", 32'(mem_we), 32'h1);
          chk("toMemAddr", mem_addr, 32'h2000);
          chk("toMemWdata", mem_wdata, 32'h12345678);
        end
      end
      if (dma_ack) gotAck = 1'b1;
    end
    chk("toEnCycles", 32'(enCnt), 32'd255);
    chk("toGotAck", 32'(gotAck), 32'h1);
    @(posedge clk); #1 dma_req = 1'b0; dma_we = 1'b0;

    // One-cycle reset during ACCESS, then a normal CPU read
    @(posedge clk); #1 cpu_we = 1'b0; cpu_addr = 32'h500; cpu_req = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    chk("rstInAccess", 32'(mem_en), 32'h1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstMemEn", 32'(mem_en), 32'h0);
    chk("rstBusy", 32'(busy), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstNoAck", 32'({cpu_ack, dma_ack}), 32'h0);
    end
    ackDelay = 1;
    @(posedge clk); #1;
    expQ.push_back('{1'b0, 32'h5A5A0600, 1'b0});
    cpu_addr = 32'h600; cpu_req = 1'b1; t0 = cyc;
    waitAck(20, tAck);
    chk("postRstLatency", 32'(tAck - t0), 32'd4);
    @(posedge clk); #1 cpu_req = 1'b0;

    // Request fields change after latching: mem_addr must stay 0x10
    ackDelay = 4;
    @(posedge clk); #1;
    expQ.push_back('{1'b0, 32'h5A5A0010, 1'b0});
    cpu_addr = 32'h10; cpu_req = 1'b1;
    @(posedge clk); #1 cpu_addr = 32'h20;
    gotAck = 1'b0;
    for (int i = 0; i < 20 && !gotAck; i++) begin
      @(negedge clk);
      if (mem_en) chk("addrHeld", mem_addr, 32'h10);
      if (cpu_ack) gotAck = 1'b1;
    end
    chk("addrGotAck", 32'(gotAck), 32'h1);
    @(posedge clk); #1 cpu_req = 1'b0;

    // Spurious mem_ack while IDLE
    repeat (2) @(posedge clk);
    #1 spurious = 1'b1;
    @(posedge clk); #1 spurious = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("spuriousIgnored", 32'({cpu_ack, dma_ack, busy, mem_en}), 32'h0);
    end

    chk("queueEmpty", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter CPU_BURST_MAX, default 4: the maximum number of consecutive CPU grants while DMA is waiting.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: the number of mem_en cycles without mem_ack before the access is aborted.
REQ-003 SHALL have ports, clock and reset first:
  clk  in  1  clock
  rst_n  in  1  reset, synchronous, active-low
  cpu_req  in  1  CPU data-port request
  cpu_we  in  1  CPU write (1) / read (0)
  cpu_addr  in  32  CPU address
  cpu_wdata  in  32  CPU write data
  cpu_ack  out  1  CPU completion pulse
  cpu_rdata  out  32  CPU read data
  cpu_err  out  1  CPU timeout flag, valid with cpu_ack
  dma_req  in  1  DMA request
  dma_we  in  1  DMA write / read
  dma_addr  in  32  DMA address
  dma_wdata  in  32  DMA write data
  dma_ack  out  1  DMA completion pulse
  dma_rdata  out  32  DMA read data
  dma_err  out  1  DMA timeout flag, valid with dma_ack
  mem_en  out  1  memory access active
  mem_we  out  1  memory write
  mem_addr  out  32  memory address
  mem_wdata  out  32  memory write data
  mem_rdata  in  32  memory read data
  mem_ack  in  1  memory completion pulse (variable latency)
  busy  out  1  arbiter not in IDLE

Function
REQ-004 SHALL use FSM states IDLE, ACCESS and RESP, all outputs registered.
REQ-005 IDLE: when any req=1 in cycle N, SHALL latch the winner's we/addr/wdata and the grant owner, go to ACCESS, and assert mem_en with the latched fields in cycle N+1.
REQ-006 Arbitration: CPU SHALL win over DMA, except that DMA SHALL win when the consecutive-CPU-grant counter equals CPU_BURST_MAX.
REQ-007 The consecutive-CPU-grant counter SHALL increment on each CPU grant made while dma_req=1, SHALL saturate at CPU_BURST_MAX, and SHALL clear on a DMA grant or in any IDLE cycle with dma_req=0.
REQ-008 ACCESS: mem_en, mem_we, mem_addr and mem_wdata SHALL be held stable until mem_ack=1 or timeout. The timeout counter SHALL start at 0 on entry and increment each ACCESS cycle.
REQ-009 On mem_ack=1 in ACCESS, SHALL capture mem_rdata (reads only; writes return 0), deassert mem_en the next cycle, and go to RESP.
REQ-010 Timeout: when the counter reaches TIMEOUT_CYCLES without mem_ack, SHALL go to RESP with err=1 and rdata=0.
REQ-011 RESP: SHALL pulse the owner's ack for exactly one cycle with rdata/err valid, keep the non-owner's ack=0, and return to IDLE.
REQ-012 Minimum requester latency SHALL be 3 cycles (req seen N, mem_en N+1, mem_ack N+1, ack N+3). An IDLE turnaround cycle SHALL always separate accesses.
REQ-013 Requesters SHALL hold req and fields until ack. The arbiter SHALL ignore field changes after latching.
REQ-014 Outside RESP, rdata and err SHALL be 0. mem_ack arriving outside ACCESS SHALL be ignored.
REQ-015 Simultaneous cpu_req and dma_req in IDLE SHALL resolve per REQ-006 in the same cycle. The loser's req SHALL remain pending with no loss.
REQ-016 busy SHALL be 1 in ACCESS and RESP and 0 in IDLE.

Reset
REQ-017 While rst_n=0 at a clk edge, SHALL enter IDLE and drive all outputs to 0, grant counter=0, timeout counter=0.
REQ-018 Reset mid-ACCESS SHALL drop mem_en the next cycle and SHALL issue no ack.

Structure
REQ-019 The state enum, owner encoding (OWN_CPU, OWN_DMA) and default parameter constants SHALL reside in shared package mem_arb_pkg.
REQ-020 One sub-module, mem_arb_prio (combinational winner select plus burst counter), SHALL be instantiated. The FSM and datapath registers SHALL stay in mem_port_arbiter.

Verification
REQ-021 CPU read of addr 0x100, mem_ack 2 cycles after mem_en with mem_rdata 0xDEADBEEF -> cpu_ack one cycle, cpu_rdata=0xDEADBEEF, cpu_err=0, dma_ack=0.
REQ-022 cpu_req and dma_req held continuously with mem_ack immediate -> grant sequence C,C,C,C,D,C,C,C,C,D.
REQ-023 DMA write of 0x12345678 to 0x2000, mem_ack withheld -> mem_en held 255 cycles, then dma_ack=1, dma_err=1, dma_rdata=0.
REQ-024 rst_n=0 for 1 cycle during ACCESS -> mem_en=0 the next cycle, no ack, busy=0. A new cpu_req is then served normally.
REQ-025 cpu_addr changed 0x10->0x20 during ACCESS -> mem_addr stays 0x10 until mem_ack. A spurious mem_ack in IDLE -> no ack is produced.
